// File: rtl/rom_mp_pipe.sv
// -----------------------------------------------------------------------------
// rom_mp_pipe
//   Loadable lookup table with Port_Num independent read ports. Each read port
//   has its own Rd_Lat-deep data/valid pipeline. A single load port writes the
//   shared array. Array contents are never reset, so they survive rst.
//
// Parameters
//   Word_Width : data word width in bits
//   Addr_Width : address width, depth = 2**Addr_Width words
//   Port_Num   : number of read ports (1..4)
//   Rd_Lat     : read latency in cycles (1..4)
//
// Ports
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-high reset of pipelines and valids
//   cen_i     : per-port chip enable, low active (0 = accept a read)
//   oen_i     : per-port output enable, low active (1 = data_o port is Z)
//   addr_i    : per-port read address, port p at [p*Addr_Width +: Addr_Width]
//   data_o    : per-port read data, port p at [p*Word_Width +: Word_Width]
//   valid_o   : per-port one-cycle pulse, aligned with the returned data
//   ld_en_i   : load enable, high active
//   ld_addr_i : load address
//   ld_data_i : load data
// -----------------------------------------------------------------------------
module rom_mp_pipe #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8,
  parameter int Port_Num   = 2,
  parameter int Rd_Lat     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [Port_Num-1:0]            cen_i,
  input  logic [Port_Num-1:0]            oen_i,
  input  logic [Port_Num*Addr_Width-1:0] addr_i,
  output logic [Port_Num*Word_Width-1:0] data_o,
  output logic [Port_Num-1:0]            valid_o,
  input  logic                           ld_en_i,
  input  logic [Addr_Width-1:0]          ld_addr_i,
  input  logic [Word_Width-1:0]          ld_data_i
);

  localparam int Depth = 2 ** Addr_Width;

  // Parameter range guards, evaluated at elaboration.
  if (Rd_Lat < 1 || Rd_Lat > 4) begin : g_bad_lat
    $error("rom_mp_pipe: Rd_Lat must be within 1..4");
  end
  if (Port_Num < 1 || Port_Num > 4) begin : g_bad_ports
    $error("rom_mp_pipe: Port_Num must be within 1..4");
  end

  logic [Word_Width-1:0] mem_r [Depth];
  logic                  load_ok_s;

  // Loads are suppressed while reset is held.
  assign load_ok_s = ld_en_i & ~rst;

  // Shared storage write port; no reset so contents survive rst. Reads in the
  // port pipelines sample the pre-edge value, giving read-before-write.
  always_ff @(posedge clk) begin
    if (load_ok_s) begin
      mem_r[ld_addr_i] <= ld_data_i;
    end
  end

  for (genvar p = 0; p < Port_Num; p++) begin : g_port
    logic [Addr_Width-1:0] rd_addr_s;
    logic [Word_Width-1:0] stage_data_r [Rd_Lat];
    logic [Rd_Lat-1:0]     stage_vld_r;

    assign rd_addr_s = addr_i[p*Addr_Width +: Addr_Width];

    // Read pipeline: stage 0 captures on an accepted read and otherwise holds,
    // so the last stage keeps showing the most recent word once drained.
    // Later stages shift every cycle without stalling.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < Rd_Lat; s++) begin
          stage_data_r[s] <= {Word_Width{1'b0}};
        end
        stage_vld_r <= {Rd_Lat{1'b0}};
      end else begin
        if (!cen_i[p]) begin
          stage_data_r[0] <= mem_r[rd_addr_s];
        end
        stage_vld_r[0] <= ~cen_i[p];
        for (int s = 1; s < Rd_Lat; s++) begin
          stage_data_r[s] <= stage_data_r[s-1];
          stage_vld_r[s]  <= stage_vld_r[s-1];
        end
      end
    end

    assign valid_o[p] = stage_vld_r[Rd_Lat-1];

    // Output enable only gates the pins; the pipeline keeps running underneath.
    assign data_o[p*Word_Width +: Word_Width] =
      oen_i[p] ? {Word_Width{1'bz}} : stage_data_r[Rd_Lat-1];
  end

endmodule
